uart_host: RTL and testbench

UART_HOST -- requirements
Module: uart_host

---
 rtl/uart_host_if.sv | 27 ++
 rtl/uart_host.sv | 150 +++++++++++++++
 tb/tb_uart_host.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_host_if.sv
// Bundles the UART MMIO bus and the client TX/RX byte handshakes.
// The host drives through the master modport; the UART/client side uses slave.
interface uart_host_if;
  logic        uart_cs;
  logic        uart_we;
  logic [3:0]  uart_addr;
  logic [31:0] uart_wdata;
  logic [31:0] uart_rdata;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;

  modport master (
    output uart_cs, uart_we, uart_addr, uart_wdata,
    output tx_ready, rx_valid, rx_data,
    input  uart_rdata, tx_valid, tx_data, rx_ready
  );

  modport slave (
    input  uart_cs, uart_we, uart_addr, uart_wdata,
    input  tx_ready, rx_valid, rx_data,
    output uart_rdata, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/uart_host.sv
// Polling bus master for the UART MMIO block with TX/RX byte FIFOs.
// Define UART_HOST_RX_OVF_EN to read-and-drop on RX overflow and expose a sticky rx_ovf.
module uart_host #(
  parameter int FIFO_DEPTH = 4,
  parameter int POLL_GAP   = 0
) (
  input  logic clk_in,
  input  logic rst_n,
  uart_host_if.master bus
`ifdef UART_HOST_RX_OVF_EN
  , output logic rx_ovf
`endif
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int GAP_LEN = (POLL_GAP > 1) ? POLL_GAP : 1;
  localparam int GW      = $clog2(GAP_LEN + 1);

  localparam logic [3:0] ADDR_RDR = 4'b0100;
  localparam logic [3:0] ADDR_TDR = 4'b1000;
  localparam logic [3:0] ADDR_SSR = 4'b1100;

  typedef enum logic [2:0] {IDLE, POLL, RD, RX_WAIT, WR, GAP} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   gap_cnt_reg;

  // FIFO 0 carries client TX bytes, FIFO 1 carries received bytes.
  logic [1:0]      f_push, f_pop, f_full, f_empty;
  logic [1:0][7:0] f_din, f_dout;

  logic ssr_tx_en, ssr_rx_rdy, rx_can_read;

  assign ssr_tx_en  = bus.uart_rdata[0];
  assign ssr_rx_rdy = bus.uart_rdata[1];

`ifdef UART_HOST_RX_OVF_EN
  assign rx_can_read = 1'b1;
`else
  assign rx_can_read = !f_full[1];
`endif

  assign f_din[0]  = bus.tx_data;
  assign f_push[0] = bus.tx_valid && bus.tx_ready;
  assign f_pop[0]  = (state_reg == WR);
  assign f_din[1]  = bus.uart_rdata[7:0];
  assign f_push[1] = (state_reg == RD);
  assign f_pop[1]  = bus.rx_valid && bus.rx_ready;

  // Gated by rst_n so tx_ready is low while reset is held yet high in the IDLE cycle.
  assign bus.tx_ready = rst_n && !f_full[0];
  assign bus.rx_valid = !f_empty[1];
  assign bus.rx_data  = f_dout[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [7:0]  mem_reg [FIFO_DEPTH];
      logic [AW:0] wr_ptr_reg, rd_ptr_reg;
      logic        do_push, do_pop;

      assign f_full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                           (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      assign f_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
      assign do_push     = f_push[gi] && !f_full[gi];
      assign do_pop      = f_pop[gi] && !f_empty[gi];
      assign f_dout[gi]  = mem_reg[rd_ptr_reg[AW-1:0]];

      always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end

      always_ff @(posedge clk_in) begin
        if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= f_din[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    state_next = POLL;
      POLL: begin
        if (ssr_rx_rdy && rx_can_read)     state_next = RD;
        else if (ssr_tx_en && !f_empty[0]) state_next = WR;
        else if (POLL_GAP != 0)            state_next = GAP;
      end
      RD:      state_next = RX_WAIT;
      // Wait for the UART to clear rx_data_ready so the same byte is not read twice.
      RX_WAIT: if (!ssr_rx_rdy) state_next = POLL;
      WR:      state_next = GAP;
      GAP:     if (gap_cnt_reg == '0) state_next = POLL;
      default: state_next = IDLE;
    endcase
  end

  // tx_enable only drops a cycle after the TDR write, so GAP lasts at least one cycle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                  gap_cnt_reg <= '0;
    else if (state_reg != GAP)   gap_cnt_reg <= GW'(GAP_LEN - 1);
    else if (gap_cnt_reg != '0)  gap_cnt_reg <= gap_cnt_reg - 1'b1;
  end

  always_comb begin
    bus.uart_cs    = 1'b0;
    bus.uart_we    = 1'b0;
    bus.uart_addr  = 4'b0000;
    bus.uart_wdata = 32'h0;
    unique case (state_reg)
      POLL, RX_WAIT: begin
        bus.uart_cs   = 1'b1;
        bus.uart_addr = ADDR_SSR;
      end
      RD: begin
        bus.uart_cs   = 1'b1;
        bus.uart_addr = ADDR_RDR;
      end
      WR: begin
        bus.uart_cs    = 1'b1;
        bus.uart_we    = 1'b1;
        bus.uart_addr  = ADDR_TDR;
        bus.uart_wdata = {24'h0, f_dout[0]};
      end
      default: ;
    endcase
  end

`ifdef UART_HOST_RX_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                          ovf_reg <= 1'b0;
    else if (state_reg == RD && f_full[1]) ovf_reg <= 1'b1;
  end

  assign rx_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_uart_host.sv
// Scoreboard bench for uart_host against a small UART MMIO model.
// Covers reset, TX latency, single RX read, RX/TX priority, TX backpressure, RX full and reset mid-write.
module tb_uart_host;
  localparam logic [3:0] ADDR_RDR = 4'b0100;
  localparam logic [3:0] ADDR_TDR = 4'b1000;
  localparam logic [3:0] ADDR_SSR = 4'b1100;
  localparam int TX_BUSY = 3;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  uart_host_if u_if ();
`ifdef UART_HOST_RX_OVF_EN
  logic rx_ovf;
  uart_host dut (.clk_in(clk_in), .rst_n(rst_n), .bus(u_if), .rx_ovf(rx_ovf));
`else
  uart_host dut (.clk_in(clk_in), .rst_n(rst_n), .bus(u_if));
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // UART model state
  int         cyc = 0;
  int         wr_count = 0, rd_count = 0;
  int         last_wr_cyc = 0, last_rd_cyc = 0;
  int         busy_cnt = 0, overlap_err = 0;
  logic       pend = 1'b0;
  logic       tx_hold = 1'b0, rx_hold = 1'b0;
  logic       m_rx_rdy = 1'b0;
  logic [7:0] m_rdr = 8'h00;
  logic       drop_armed = 1'b0;
  int         drop_cnt = 0, drop_delay = 4;
  logic [7:0] rx_q[$];
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];

  logic m_tx_en;
  assign m_tx_en = !tx_hold && (busy_cnt == 0);

  // Upper read bits carry junk that the host must ignore.
  always_comb begin
    if (u_if.uart_addr == ADDR_SSR)
      u_if.uart_rdata = {28'hAAAA_AAA, 1'b1, m_rx_rdy && !rx_hold, m_tx_en};
    else if (u_if.uart_addr == ADDR_RDR)
      u_if.uart_rdata = {24'hABCDEF, m_rdr};
    else
      u_if.uart_rdata = 32'hDEAD_BEEF;
  end

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (u_if.uart_cs && u_if.uart_we && u_if.uart_addr == ADDR_TDR) begin
      if (pend || busy_cnt != 0) overlap_err <= overlap_err + 1;
      wr_count    <= wr_count + 1;
      last_wr_cyc <= cyc;
      pend        <= 1'b1;
    end else if (pend) begin
      pend     <= 1'b0;
      busy_cnt <= TX_BUSY;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end

    if (u_if.uart_cs && !u_if.uart_we && u_if.uart_addr == ADDR_RDR) begin
      rd_count    <= rd_count + 1;
      last_rd_cyc <= cyc;
      drop_armed  <= 1'b1;
      drop_cnt    <= drop_delay;
    end else if (drop_armed) begin
      if (drop_cnt == 0) begin
        m_rx_rdy   <= 1'b0;
        drop_armed <= 1'b0;
      end else begin
        drop_cnt <= drop_cnt - 1;
      end
    end else if (!m_rx_rdy && rx_q.size() != 0) begin
      m_rdr    <= rx_q.pop_front();
      m_rx_rdy <= 1'b1;
    end
  end

  // Monitor: every TDR write and every RX handshake is matched against the scoreboard.
  always @(negedge clk_in) begin
    if (u_if.uart_cs && u_if.uart_we) begin
      if (tx_exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL tdr_unexpected: got write 0x%0h, required no write", u_if.uart_wdata);
      end else begin
        logic [7:0] e;
        e = tx_exp_q.pop_front();
        check("tdr_addr", {28'h0, u_if.uart_addr}, {28'h0, ADDR_TDR});
        check("tdr_wdata", u_if.uart_wdata, {24'h0, e});
      end
    end
    if (u_if.rx_valid && u_if.rx_ready) begin
      if (rx_exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rx_unexpected: got rx_data 0x%0h, required no byte", u_if.rx_data);
      end else begin
        logic [7:0] e;
        e = rx_exp_q.pop_front();
        check("rx_data", {24'h0, u_if.rx_data}, {24'h0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, w0, r0;
    logic [7:0] bytes [5];
    bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'hFF; bytes[3] = 8'h7E; bytes[4] = 8'hC3;

    u_if.tx_valid = 1'b0;
    u_if.tx_data  = 8'h00;
    u_if.rx_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_cs", u_if.uart_cs, 0);
    check("rst_we", u_if.uart_we, 0);
    check("rst_addr", u_if.uart_addr, 0);
    check("rst_wdata", u_if.uart_wdata, 0);
    check("rst_tx_ready", u_if.tx_ready, 0);
    check("rst_rx_valid", u_if.rx_valid, 0);
`ifdef UART_HOST_RX_OVF_EN
    check("rst_rx_ovf", rx_ovf, 0);
`endif
    rst_n = 1'b1;
    #1;
    check("idle_tx_ready", u_if.tx_ready, 1);
    check("idle_cs", u_if.uart_cs, 0);
    step();
    check("poll_cs", u_if.uart_cs, 1);
    check("poll_addr", u_if.uart_addr, ADDR_SSR);
    step();

    // TX latency with the UART idle
    hs = cyc;
    check("tx_ready_idle", u_if.tx_ready, 1);
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = 8'h55;
    tx_exp_q.push_back(8'h55);
    w0 = wr_count;
    step();
    u_if.tx_valid = 1'b0;
    for (int k = 0; k < 50 && wr_count == w0; k++) step();
    check("tx_written", wr_count - w0, 1);
    check("tx_latency", last_wr_cyc - hs, 2);
    repeat (8) step();

    // Single RX byte, SSR[1] dropped 5 cycles after the read
    drop_delay = 4;
    r0 = rd_count;
    rx_exp_q.push_back(8'hA5);
    rx_q.push_back(8'hA5);
    for (int k = 0; k < 50 && rd_count == r0; k++) step();
    repeat (15) step();
    check("rx_single_read", rd_count - r0, 1);
    check("rx_a5_delivered", rx_exp_q.size(), 0);

    // RX has priority over TX when SSR = 0x3
    tx_hold = 1'b1;
    rx_hold = 1'b1;
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = 8'h3C;
    tx_exp_q.push_back(8'h3C);
    rx_q.push_back(8'h96);
    rx_exp_q.push_back(8'h96);
    step();
    u_if.tx_valid = 1'b0;
    repeat (3) step();
    r0 = rd_count;
    w0 = wr_count;
    tx_hold = 1'b0;
    rx_hold = 1'b0;
    for (int k = 0; k < 60 && (rd_count == r0 || wr_count == w0); k++) step();
    check("prio_both_done", (rd_count - r0) + (wr_count - w0), 2);
    check("prio_rd_first", last_rd_cyc < last_wr_cyc, 1);
    repeat (8) step();

    // TX backpressure: 4 pushes fill the FIFO while tx_enable is held low
    tx_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_if.tx_valid = 1'b1;
      u_if.tx_data  = bytes[i];
      check("txfill_ready", u_if.tx_ready, 1);
      tx_exp_q.push_back(bytes[i]);
      step();
    end
    u_if.tx_data = bytes[4];
    check("txfull_ready", u_if.tx_ready, 0);
    step();
    check("txfull_ready_held", u_if.tx_ready, 0);
    tx_hold = 1'b0;
    for (int k = 0; k < 100 && !u_if.tx_ready; k++) step();
    check("txfull_ready_back", u_if.tx_ready, 1);
    tx_exp_q.push_back(bytes[4]);
    step();
    u_if.tx_valid = 1'b0;
    for (int k = 0; k < 200 && tx_exp_q.size() != 0; k++) step();
    check("txfull_all_written", tx_exp_q.size(), 0);
    repeat (8) step();
    check("tx_one_write_per_window", overlap_err, 0);

    // RX FIFO full with rx_ready low
    u_if.rx_ready = 1'b0;
    drop_delay = 1;
    r0 = rd_count;
    for (int i = 0; i < 5; i++) begin
      rx_q.push_back(8'h10 + 8'(i));
`ifdef UART_HOST_RX_OVF_EN
      if (i < 4) rx_exp_q.push_back(8'h10 + 8'(i));
`else
      rx_exp_q.push_back(8'h10 + 8'(i));
`endif
    end
    repeat (80) step();
`ifdef UART_HOST_RX_OVF_EN
    check("rxfull_reads", rd_count - r0, 5);
    check("rxfull_ovf", rx_ovf, 1);
`else
    check("rxfull_reads", rd_count - r0, 4);
`endif
    check("rxfull_valid", u_if.rx_valid, 1);
    check("rxfull_head", u_if.rx_data, 8'h10);
    u_if.rx_ready = 1'b1;
    for (int k = 0; k < 200 && (rx_exp_q.size() != 0 || u_if.rx_valid); k++) step();
    check("rxfull_drained", rx_exp_q.size(), 0);
    check("rxfull_empty", u_if.rx_valid, 0);
    check("rxfull_total_reads", rd_count - r0, 5);
    repeat (4) step();

    // Reset asserted during WR aborts the write and empties both FIFOs
    u_if.rx_ready = 1'b0;
    r0 = rd_count;
    rx_q.push_back(8'h5A);
    for (int k = 0; k < 50 && rd_count == r0; k++) step();
    repeat (3) step();
    check("rst_rx_pending", u_if.rx_valid, 1);
    tx_hold = 1'b1;
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = 8'h77;
    step();
    u_if.tx_data  = 8'h78;
    step();
    u_if.tx_valid = 1'b0;
    w0 = wr_count;
    tx_hold = 1'b0;
    for (int k = 0; k < 50 && !(u_if.uart_cs && u_if.uart_we); k++) step();
    check("rst_wr_seen", u_if.uart_cs && u_if.uart_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cs", u_if.uart_cs, 0);
    check("arst_we", u_if.uart_we, 0);
    check("arst_addr", u_if.uart_addr, 0);
    check("arst_wdata", u_if.uart_wdata, 0);
    check("arst_tx_ready", u_if.tx_ready, 0);
    check("arst_rx_valid", u_if.rx_valid, 0);
`ifdef UART_HOST_RX_OVF_EN
    check("arst_rx_ovf", rx_ovf, 0);
`endif
    step();
    step();
    check("arst_no_write", wr_count - w0, 0);
    rst_n = 1'b1;
    #1;
    check("rel_idle_cs", u_if.uart_cs, 0);
    check("rel_tx_ready", u_if.tx_ready, 1);
    check("rel_rx_valid", u_if.rx_valid, 0);
    step();
    check("rel_poll_cs", u_if.uart_cs, 1);
    check("rel_poll_we", u_if.uart_we, 0);
    check("rel_poll_addr", u_if.uart_addr, ADDR_SSR);
    repeat (20) step();
    check("rel_tx_fifo_empty", wr_count - w0, 0);
    check("rel_rx_fifo_empty", u_if.rx_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
